// File: rtl/cuenta_digitos.sv
// ============================================================================
// cuenta_digitos: multi-cycle digit counter (and optional digit summer) for
// an unsigned operand in radix BASE. Optional macro: SUMA_DIGITOS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cuenta_digitos #(
    parameter int WIDTH = 32,
    parameter int BASE  = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] numero,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] retorno
`ifdef SUMA_DIGITOS_EN
    ,
    output logic [WIDTH-1:0] suma
`endif
);

    localparam logic [WIDTH-1:0] BASE_W = WIDTH'(BASE);
    localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CICLO  = 2'd1,
        DIVIDO = 2'd2,
        FIN    = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] work, work_n;
    logic [WIDTH-1:0] count, count_n;
    logic [WIDTH-1:0] retorno_n;
`ifdef SUMA_DIGITOS_EN
    logic [WIDTH-1:0] sum, sum_n;
    logic [WIDTH-1:0] suma_n;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            work    <= '0;
            count   <= '0;
            retorno <= '0;
`ifdef SUMA_DIGITOS_EN
            sum     <= '0;
            suma    <= '0;
`endif
        end else begin
            state   <= state_n;
            work    <= work_n;
            count   <= count_n;
            retorno <= retorno_n;
`ifdef SUMA_DIGITOS_EN
            sum     <= sum_n;
            suma    <= suma_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        work_n    = work;
        count_n   = count;
        retorno_n = retorno;
`ifdef SUMA_DIGITOS_EN
        sum_n     = sum;
        suma_n    = suma;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    work_n  = numero;
                    count_n = '0;
`ifdef SUMA_DIGITOS_EN
                    sum_n   = '0;
`endif
                    state_n = CICLO;
                end
            end
            CICLO: begin
                if (work == '0) begin
                    // Operand 0 still has one digit.
                    retorno_n = (count == '0) ? ONE_W : count;
`ifdef SUMA_DIGITOS_EN
                    suma_n    = sum;
`endif
                    state_n   = FIN;
                end else begin
                    state_n = DIVIDO;
                end
            end
            DIVIDO: begin
                work_n  = work / BASE_W;
                count_n = count + ONE_W;
`ifdef SUMA_DIGITOS_EN
                sum_n   = sum + (work % BASE_W);
`endif
                state_n = CICLO;
            end
            FIN: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == FIN);

endmodule

`default_nettype wire

// File: doc/cuenta_digitos.md
CUENTA_DIGITOS -- requirements
Module: cuenta_digitos

Interface
REQ-001 Parameter WIDTH, default 32: width of the operand, retorno and suma; legal range 8..64.
REQ-002 Parameter BASE, default 10: radix used for digit extraction; legal range 2..16.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low: asserted when 0, released synchronously to clk by the integrator.
REQ-005 start  input  1  request pulse; sampled only in state IDLE.
REQ-006 numero  input  WIDTH  operand, captured on the clk edge where start is accepted.
REQ-007 busy  output  1  high in every state other than IDLE.
REQ-008 done  output  1  one-cycle pulse, high exactly while in state FIN.
REQ-009 retorno  output  WIDTH  number of base-BASE digits of the captured operand.
REQ-010 suma  output  WIDTH  sum of base-BASE digits of the captured operand; present only with SUMA_DIGITOS_EN.

Function
REQ-011 The FSM SHALL have four states: IDLE, CICLO, DIVIDO, FIN.
REQ-012 IDLE: start=1 -> load the working register with numero, clear the count and sum, go to CICLO; start=0 -> stay in IDLE.
REQ-013 CICLO: working register == 0 -> FIN; otherwise -> DIVIDO.
REQ-014 DIVIDO: working register <= working register / BASE; count <= count + 1; sum <= sum + (working register % BASE); then -> CICLO.
REQ-015 FIN: done=1 for one cycle; retorno (and suma) load on the edge entering FIN; then -> IDLE unconditionally.
REQ-016 Operand 0 SHALL report retorno=1 and suma=0; the count is forced to 1 when it is 0 at entry to FIN.
REQ-017 Latency SHALL be exactly 2*d+2 clk edges from the accepting edge until done is high, where d is the digit count (d=0 for operand 0).
REQ-018 retorno and suma SHALL hold their last result until the next entry to FIN; they SHALL not change during busy.
REQ-019 start SHALL be ignored while busy=1, including during FIN; numero changes while busy SHALL have no effect.
REQ-020 Division and modulo SHALL be unsigned and computed in a single cycle; the count and sum cannot overflow WIDTH and need no saturation.
REQ-021 The next-state and datapath logic SHALL assign every variable in every state, with no inferred latches.

Reset
REQ-022 rst=0 SHALL force the following immediately, without waiting for clk: state=IDLE; busy=0; done=0; retorno=0; suma=0; working register, count and sum cleared.
REQ-023 Reset asserted mid-operation SHALL abort the computation with no done pulse; the first start after release SHALL behave as after power-up.

Configuration
REQ-024 Macro SUMA_DIGITOS_EN defined: the suma port and the digit-sum accumulator are present and behave as in REQ-014 to REQ-016.
REQ-025 Macro SUMA_DIGITOS_EN undefined: the suma port and the accumulator are absent; all other behaviour and timing are identical.

Verification
REQ-026 BASE=10, numero=12345, start pulse -> done 12 edges later, retorno=5, suma=15.
REQ-027 BASE=10, numero=0 -> done 2 edges later, retorno=1, suma=0.
REQ-028 BASE=10, numero=32'hFFFFFFFF -> retorno=10, suma=57, done after 22 edges; BASE=16 build, same operand -> retorno=8, suma=120, done after 18 edges.
REQ-029 numero=999 run in progress, second start with numero=7 while busy -> ignored; retorno=3, suma=27, exactly one done pulse.
REQ-030 rst driven low during DIVIDO of a numero=12345 run -> busy, done, retorno and suma are 0 immediately, no done pulse; after release, numero=42 -> retorno=2, suma=6.
REQ-031 Build without SUMA_DIGITOS_EN, numero=12345 -> retorno=5 with identical 12-edge latency; the suma port does not exist.
